// File: rtl/alu_operand_stage.sv
// alu_operand_stage: resolves ALU operands from register data, forwarding
// results, immediate and PC. Delivers them through a registered main stage
// backed by a one-entry skid buffer, so in_ready never depends on out_ready.
module alu_operand_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] rd1,
   input  logic [DATA_WIDTH-1:0] rd2,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic                  alu_src,
   input  logic                  a_sel,
   input  logic [1:0]            fwd_a,
   input  logic [1:0]            fwd_b,
   input  logic [DATA_WIDTH-1:0] ex_fwd,
   input  logic [DATA_WIDTH-1:0] mem_fwd,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] op_a,
   output logic [DATA_WIDTH-1:0] op_b,
   output logic [DATA_WIDTH-1:0] store_data
);

   typedef enum logic [1:0] {
      FWD_REG0 = 2'b00,
      FWD_EX   = 2'b01,
      FWD_MEM  = 2'b10,
      FWD_REG3 = 2'b11
   } fwd_sel_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic [DATA_WIDTH-1:0] sd;
   } bundle_t;

   logic    main_valid;
   logic    skid_valid;
   bundle_t main_q;
   bundle_t skid_q;
   bundle_t next_bundle;
   logic [DATA_WIDTH-1:0] fwd_a_val;
   logic [DATA_WIDTH-1:0] fwd_b_val;
   logic accept;
   logic pop;
   logic skid_load;

   assign in_ready  = !skid_valid && !rst;
   assign accept    = in_valid && in_ready && !flush;
   assign pop       = main_valid && out_ready;
   assign skid_load = accept && main_valid && !pop;

   assign out_valid  = main_valid;
   assign op_a       = main_q.a;
   assign op_b       = main_q.b;
   assign store_data = main_q.sd;

   // Resolve forwarded sources, then apply the A/B operand selects.
   always_comb begin
      // NOTE: every output of this block gets a value before any branch, so
      // no path can leave it unassigned and infer a latch.
      fwd_a_val   = rd1;
      fwd_b_val   = rd2;
      next_bundle = '0;
      unique case (fwd_sel_e'(fwd_a))
         FWD_EX:   fwd_a_val = ex_fwd;
         FWD_MEM:  fwd_a_val = mem_fwd;
         default:  fwd_a_val = rd1;
      endcase
      unique case (fwd_sel_e'(fwd_b))
         FWD_EX:   fwd_b_val = ex_fwd;
         FWD_MEM:  fwd_b_val = mem_fwd;
         default:  fwd_b_val = rd2;
      endcase
      next_bundle.a  = a_sel   ? pc  : fwd_a_val;
      next_bundle.b  = alu_src ? imm : fwd_b_val;
      next_bundle.sd = fwd_b_val;
   end

   // Main register and both valid bits: reset beats flush, flush beats accept/pop.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (pop) begin
         if (skid_valid) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_q     <= next_bundle;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         if (main_valid) begin
            skid_valid <= 1'b1;
         end else begin
            main_q     <= next_bundle;
            main_valid <= 1'b1;
         end
      end
   end

   // Skid data capture; only meaningful while skid_valid is set.
   always_ff @(posedge clk) begin
      // NOTE: skid data has no reset; skid_valid alone says whether it is live,
      // so resetting the payload would only add reset fan-out.
      if (skid_load) begin
         skid_q <= next_bundle;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed testbench for alu_operand_stage: operand selection, forwarding,
// skid backpressure, flush and reset behaviour.
module tb_alu_operand_stage;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] rd1, rd2, imm, pc, ex_fwd, mem_fwd;
   logic         alu_src, a_sel;
   logic [1:0]   fwd_a, fwd_b;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] op_a, op_b, store_data;

   int n_cmp = 0;
   int n_err = 0;

   alu_operand_stage #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .rd1(rd1), .rd2(rd2), .imm(imm), .pc(pc), .alu_src(alu_src),
      .a_sel(a_sel), .fwd_a(fwd_a), .fwd_b(fwd_b), .ex_fwd(ex_fwd),
      .mem_fwd(mem_fwd), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .op_a(op_a), .op_b(op_b), .store_data(store_data)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a plain register bundle (no forwarding, no pc, no imm).
   task automatic drive_reg(input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid = 1'b1; rd1 = a; rd2 = b;
      a_sel = 1'b0; alu_src = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      rd1 = '0; rd2 = '0; imm = '0; pc = '0; ex_fwd = '0; mem_fwd = '0;
      alu_src = 1'b0; a_sel = 1'b0; fwd_a = 2'b00; fwd_b = 2'b00;
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (op_a !== 32'h0) begin n_err++; $display("FAIL rst_op_a: got %h expected 0", op_a); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
      rst = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_imm();
      drive_reg(32'h5, 32'h7);
      imm = 32'hFFFF_FFF0; alu_src = 1'b1;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL imm_out_valid: got %b expected 1", out_valid); end
      n_cmp++; if (op_a !== 32'h5) begin n_err++; $display("FAIL imm_op_a: got %h expected 5", op_a); end
      n_cmp++; if (op_b !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL imm_op_b: got %h expected fffffff0", op_b); end
      n_cmp++; if (store_data !== 32'h7) begin n_err++; $display("FAIL imm_store: got %h expected 7", store_data); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL imm_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_forward();
      drive_reg(32'hAAAA, 32'hBBBB);
      ex_fwd = 32'h11; mem_fwd = 32'h22; fwd_a = 2'b01; fwd_b = 2'b10;
      tick();
      n_cmp++; if (op_a !== 32'h11) begin n_err++; $display("FAIL fwd_ex_a: got %h expected 11", op_a); end
      n_cmp++; if (op_b !== 32'h22) begin n_err++; $display("FAIL fwd_mem_b: got %h expected 22", op_b); end
      n_cmp++; if (store_data !== 32'h22) begin n_err++; $display("FAIL fwd_mem_sd: got %h expected 22", store_data); end
      fwd_a = 2'b10; fwd_b = 2'b11;
      tick();
      n_cmp++; if (op_a !== 32'h22) begin n_err++; $display("FAIL fwd_mem_a: got %h expected 22", op_a); end
      n_cmp++; if (op_b !== 32'hBBBB) begin n_err++; $display("FAIL fwd_reg3_b: got %h expected bbbb", op_b); end
      n_cmp++; if (store_data !== 32'hBBBB) begin n_err++; $display("FAIL fwd_reg3_sd: got %h expected bbbb", store_data); end
      fwd_a = 2'b11; fwd_b = 2'b01;
      tick();
      n_cmp++; if (op_a !== 32'hAAAA) begin n_err++; $display("FAIL fwd_reg3_a: got %h expected aaaa", op_a); end
      n_cmp++; if (op_b !== 32'h11) begin n_err++; $display("FAIL fwd_ex_b: got %h expected 11", op_b); end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_pc();
      drive_reg(32'hAAAA, 32'hBBBB);
      a_sel = 1'b1; pc = 32'h100; fwd_a = 2'b01; ex_fwd = 32'h11;
      alu_src = 1'b1; imm = 32'h4;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (op_a !== 32'h100) begin n_err++; $display("FAIL pc_op_a: got %h expected 100", op_a); end
      n_cmp++; if (op_b !== 32'h4) begin n_err++; $display("FAIL pc_op_b: got %h expected 4", op_b); end
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      drive_reg(32'hA1, 32'hA2);
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_main: got %b expected 1", in_ready); end
      drive_reg(32'hB1, 32'hB2);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_skid: got %b expected 0", in_ready); end
      tick();
      n_cmp++; if (op_a !== 32'hA1 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_hold: got %h/%b expected a1/1", op_a, out_valid); end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (op_a !== 32'hB1 || store_data !== 32'hB2) begin n_err++; $display("FAIL b2b_second: got %h/%h expected b1/b2", op_a, store_data); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after: got %b expected 1", in_ready); end
      drive_reg(32'hC1, 32'hC2);
      tick();
      drive_reg(32'hD1, 32'hD2);
      n_cmp++; if (op_a !== 32'hC1 || out_valid !== 1'b1) begin n_err++; $display("FAIL stream_c: got %h/%b expected c1/1", op_a, out_valid); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (op_a !== 32'hD1 || out_valid !== 1'b1) begin n_err++; $display("FAIL stream_d: got %h/%b expected d1/1", op_a, out_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive_reg(32'hA1, 32'hA2);
      tick();
      drive_reg(32'hB1, 32'hB2);
      tick();
      drive_reg(32'hC1, 32'hC2);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full_valid: got %b expected 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_full_ready: got %b expected 1", in_ready); end
      drive_reg(32'hE1, 32'hE2);
      tick();
      drive_reg(32'hF1, 32'hF2);
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_blocks_accept: got %b expected 0", out_valid); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_late: got %b expected 0", out_valid); end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_held();
      out_ready = 1'b0;
      drive_reg(32'h77, 32'h88);
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rh_loaded: got %b expected 1", out_valid); end
      rst = 1'b1;
      drive_reg(32'h99, 32'h99);
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rh_ready_in_rst: got %b expected 0", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rh_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (op_a !== '0 || op_b !== '0 || store_data !== '0) begin n_err++; $display("FAIL rh_zero: got %h/%h/%h expected 0/0/0", op_a, op_b, store_data); end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rh_ready_after: got %b expected 1", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rh_discarded: got %b expected 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_imm();
      test_forward();
      test_pc();
      test_back_to_back();
      test_flush();
      test_reset_held();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
